// File: rtl/bus_arb_xbar_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bus_arb_xbar_pkg                                               |
// | Brief   : shared state encoding and slave map for the bus crossbar       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package bus_arb_xbar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Width of the slave-select field taken from the top of the address.
    localparam int C_SEL_W    = 4;

    localparam int C_SLV_ROM  = 0;
    localparam int C_SLV_RAM  = 1;
    localparam int C_SLV_GPIO = 2;

endpackage
`default_nettype wire

// File: rtl/bus_arb_xbar_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bus_arb_xbar_rr_arbiter                                        |
// | Brief   : combinational round-robin arbiter, priority starts after last  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bus_arb_xbar_rr_arbiter #(
    parameter int NUM_M = 2,
    parameter int IDX_W = 1
) (
    input  logic [NUM_M-1:0] i_req,
    input  logic [IDX_W-1:0] i_last_gnt,
    output logic [NUM_M-1:0] o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_gnt_vld
);

    // Each requester's distance from the slot after the last winner; nearest wins.
    always_comb begin
        int w_dist;
        int w_best;
        w_dist    = 0;
        w_best    = NUM_M;
        o_gnt_idx = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (i_req[i]) begin
                w_dist = i - int'(i_last_gnt) - 1;
                if (w_dist < 0) begin
                    w_dist = w_dist + NUM_M;
                end
                if (w_dist < w_best) begin
                    w_best    = w_dist;
                    o_gnt_idx = IDX_W'(i);
                end
            end
        end
        o_gnt_vld = |i_req;
        o_gnt     = o_gnt_vld ? (NUM_M'(1) << o_gnt_idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/bus_arb_xbar.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bus_arb_xbar                                                   |
// | Brief   : NUM_M x NUM_S shared-bus interconnect, round-robin arbitration |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bus_arb_xbar
    import bus_arb_xbar_pkg::*;
#(
    parameter int NUM_M  = 2,
    parameter int NUM_S  = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_M-1:0]          m_req_i,
    input  logic [NUM_M-1:0]          m_we_i,
    input  logic [NUM_M*ADDR_W-1:0]   m_addr_i,
    input  logic [NUM_M*DATA_W-1:0]   m_wdata_i,
    output logic [NUM_M*DATA_W-1:0]   m_rdata_o,
    output logic [NUM_M-1:0]          m_ack_o,
    output logic [NUM_M-1:0]          m_err_o,
    output logic [NUM_S*ADDR_W-1:0]   s_addr_o,
    output logic [NUM_S-1:0]          s_we_o,
    output logic [NUM_S*DATA_W-1:0]   s_wdata_o,
    input  logic [NUM_S*DATA_W-1:0]   s_rdata_i,
    output logic [NUM_M-1:0]          hold_flag_o
);

    localparam int IDX_W = $clog2(NUM_M);
    localparam int LOW_W = ADDR_W - C_SEL_W;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IDX_W-1:0]       r_gnt;
    logic [LOW_W-1:0]       r_addr;
    logic                   r_we;
    logic [DATA_W-1:0]      r_wdata;
    logic [C_SEL_W-1:0]     r_sel;

    logic                   w_dec_err;
    logic                   w_latch;
    logic [NUM_M-1:0]       w_arb_req;
    logic [NUM_M-1:0]       w_arb_gnt;
    logic [IDX_W-1:0]       w_arb_idx;
    logic                   w_arb_vld;
    logic [ADDR_W-1:0]      w_win_addr;
    logic                   w_win_we;
    logic [DATA_W-1:0]      w_win_wdata;
    logic [DATA_W-1:0]      w_sel_rdata;

    assign w_dec_err = (int'(r_sel) >= NUM_S);

    // In DATA the master being acked still holds its old request, so mask it out.
    assign w_arb_req = (r_state == ST_DATA) ? (m_req_i & ~(NUM_M'(1) << r_gnt)) : m_req_i;

    bus_arb_xbar_rr_arbiter #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req      (w_arb_req),
        .i_last_gnt (r_gnt),
        .o_gnt      (w_arb_gnt),
        .o_gnt_idx  (w_arb_idx),
        .o_gnt_vld  (w_arb_vld)
    );

    always_comb begin
        w_win_addr  = '0;
        w_win_we    = 1'b0;
        w_win_wdata = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (w_arb_gnt[i]) begin
                w_win_addr  = m_addr_i[i*ADDR_W +: ADDR_W];
                w_win_we    = m_we_i[i];
                w_win_wdata = m_wdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_vld) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                w_state_nxt = (r_we || w_dec_err) ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                w_latch     = w_arb_vld;
                w_state_nxt = w_arb_vld ? ST_ADDR : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_ack_o     = '0;
        m_err_o     = '0;
        m_rdata_o   = '0;
        s_addr_o    = '0;
        s_we_o      = '0;
        s_wdata_o   = '0;
        w_sel_rdata = '0;
        for (int k = 0; k < NUM_S; k++) begin
            if (int'(r_sel) == k) begin
                w_sel_rdata = s_rdata_i[k*DATA_W +: DATA_W];
                if (r_state == ST_ADDR) begin
                    s_addr_o[k*ADDR_W +: ADDR_W]  = {{C_SEL_W{1'b0}}, r_addr};
                    s_we_o[k]                     = r_we;
                    s_wdata_o[k*DATA_W +: DATA_W] = r_wdata;
                end
            end
        end
        for (int i = 0; i < NUM_M; i++) begin
            if (int'(r_gnt) == i) begin
                if (r_state == ST_ADDR && (r_we || w_dec_err)) begin
                    m_ack_o[i] = 1'b1;
                    m_err_o[i] = w_dec_err;
                end
                if (r_state == ST_DATA) begin
                    m_ack_o[i]                    = 1'b1;
                    m_rdata_o[i*DATA_W +: DATA_W] = w_sel_rdata;
                end
            end
        end
    end

    assign hold_flag_o = m_req_i & ~m_ack_o;

    // r_gnt doubles as the round-robin pointer; reset value gives master 0 top priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= IDX_W'(NUM_M - 1);
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_gnt   <= w_arb_idx;
                r_addr  <= w_win_addr[LOW_W-1:0];
                r_we    <= w_win_we;
                r_wdata <= w_win_wdata;
                r_sel   <= w_win_addr[ADDR_W-1 -: C_SEL_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_arb_xbar.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_bus_arb_xbar                                                |
// | Brief   : scoreboard bench for bus_arb_xbar, random and directed traffic |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_bus_arb_xbar;

    localparam int NM       = 4;
    localparam int NS       = 3;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int TMO      = 64;
    localparam int WAIT_MAX = 2*NM + 4;

    typedef struct {
        bit          we;
        bit          err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NM-1:0]    m_req, m_we, m_ack, m_err, hold;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wdata, m_rdata;
    logic [NS*AW-1:0] s_addr;
    logic [NS-1:0]    s_we;
    logic [NS*DW-1:0] s_wdata, s_rdata;

    logic             req_a  [NM];
    logic             we_a   [NM];
    logic [31:0]      addr_a [NM];
    logic [31:0]      wd_a   [NM];

    exp_t             exp_q [NM][$];
    int               ack_m[$];
    int               ack_c[$];
    int               checks = 0;
    int               fails  = 0;
    int               cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NM; i++) begin
            m_req[i]             = req_a[i];
            m_we[i]              = we_a[i];
            m_addr[i*AW +: AW]   = addr_a[i];
            m_wdata[i*DW +: DW]  = wd_a[i];
        end
    end

    bus_arb_xbar #(
        .NUM_M (NM),
        .NUM_S (NS),
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m_req_i    (m_req),
        .m_we_i     (m_we),
        .m_addr_i   (m_addr),
        .m_wdata_i  (m_wdata),
        .m_rdata_o  (m_rdata),
        .m_ack_o    (m_ack),
        .m_err_o    (m_err),
        .s_addr_o   (s_addr),
        .s_we_o     (s_we),
        .s_wdata_o  (s_wdata),
        .s_rdata_i  (s_rdata),
        .hold_flag_o(hold)
    );

    // Slave content is a fixed hash of (slave, local address); read data is registered.
    function automatic logic [31:0] rom(input int k, input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ (32'(k) << 24) ^ 32'h1234_5678;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NS; k++)
            s_rdata[k*DW +: DW] <= rom(k, s_addr[k*AW +: AW]);
    end

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int          r;
        a = $urandom;
        r = int'($urandom_range(0, 7));
        a[31:28] = (r < 6) ? 4'(r % 3) : ((r == 6) ? 4'd3 : 4'd15);
        return a;
    endfunction

    task automatic issue(input int m, input bit we, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        req_a[m]  = 1'b1;
        we_a[m]   = we;
        addr_a[m] = a;
        wd_a[m]   = d;
        e.we    = we;
        e.addr  = a;
        e.wdata = d;
        e.err   = (int'(a[31:28]) >= NS);
        e.rdata = e.err ? 32'h0 : rom(int'(a[31:28]), {4'h0, a[27:0]});
        exp_q[m].push_back(e);
    endtask

    // Returns the number of negedges from request to ack inclusive; ends #1 after the following posedge.
    task automatic wait_ack(input int m, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!m_ack[m] && waited < TMO);
        if (!m_ack[m]) begin
            checks++;
            fails++;
            $display("FAIL ack_timeout master=%0d waited=%0d limit=%0d", m, waited, TMO);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_master(input int m, input int n, input bit burst);
        int          gap;
        int          w;
        bit          we;
        logic [31:0] a;
        for (int j = 0; j < n; j++) begin
            gap = burst ? 0 : int'($urandom_range(0, 2));
            if (gap > 0) begin
                req_a[m] = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            if (burst) begin
                we = 1'b0;
                a  = $urandom;
                a[31:28] = 4'($urandom_range(0, NS-1));
            end else begin
                we = 1'($urandom_range(0, 1));
                a  = rand_addr();
            end
            issue(m, we, a, $urandom);
            wait_ack(m, w);
            checks++;
            if (w > WAIT_MAX) begin
                fails++;
                $display("FAIL wait_bound master=%0d waited=%0d max=%0d", m, w, WAIT_MAX);
            end
        end
        req_a[m] = 1'b0;
    endtask

    task automatic single(input int m, input bit we, input logic [31:0] a, input logic [31:0] d,
                          input int exp_wait, input string name);
        int w;
        issue(m, we, a, d);
        wait_ack(m, w);
        req_a[m] = 1'b0;
        checks++;
        if (w != exp_wait) begin
            fails++;
            $display("FAIL %s latency got=%0d expected=%0d", name, w, exp_wait);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ((m_ack | m_err) != '0 || m_rdata != '0 || s_addr != '0 || s_we != '0 || s_wdata != '0) begin
            fails++;
            $display("FAIL %s ack=%b err=%b s_we=%b rdata=%h s_addr=%h expected all zero",
                     name, m_ack, m_err, s_we, m_rdata, s_addr);
        end
    endtask

    // Monitor: pops the expected response whenever a master sees an ack.
    always @(negedge clk) begin
        exp_t        e;
        int          sel;
        bit          wr_seen;
        if (rst) begin
            wr_seen = 1'b0;
            for (int i = 0; i < NM; i++) begin
                checks++;
                if (hold[i] !== (m_req[i] & ~m_ack[i])) begin
                    fails++;
                    $display("FAIL hold master=%0d got=%b expected=%b", i, hold[i], m_req[i] & ~m_ack[i]);
                end
                if (m_ack[i]) begin
                    ack_m.push_back(i);
                    ack_c.push_back(cyc);
                    checks++;
                    if (exp_q[i].size() == 0) begin
                        fails++;
                        $display("FAIL spurious_ack master=%0d got=1 expected=0", i);
                    end else begin
                        e = exp_q[i].pop_front();
                        if (m_err[i] !== e.err) begin
                            fails++;
                            $display("FAIL err master=%0d got=%b expected=%b addr=%h", i, m_err[i], e.err, e.addr);
                        end
                        if (!e.we || e.err) begin
                            checks++;
                            if (m_rdata[i*DW +: DW] !== e.rdata) begin
                                fails++;
                                $display("FAIL rdata master=%0d got=%h expected=%h addr=%h",
                                         i, m_rdata[i*DW +: DW], e.rdata, e.addr);
                            end
                        end
                        if (e.err) begin
                            checks++;
                            if (s_we != '0 || s_addr != '0) begin
                                fails++;
                                $display("FAIL derr_slave s_we=%b s_addr=%h expected 0", s_we, s_addr);
                            end
                        end else if (e.we) begin
                            wr_seen = 1'b1;
                            sel = int'(e.addr[31:28]);
                            checks++;
                            if (s_we !== (NS'(1) << sel) || s_addr[sel*AW +: AW] !== {4'h0, e.addr[27:0]}
                                || s_wdata[sel*DW +: DW] !== e.wdata) begin
                                fails++;
                                $display("FAIL wr_slave s_we=%b addr=%h wdata=%h expected we_sel=%0d addr=%h wdata=%h",
                                         s_we, s_addr[sel*AW +: AW], s_wdata[sel*DW +: DW],
                                         sel, {4'h0, e.addr[27:0]}, e.wdata);
                            end
                        end
                    end
                end else begin
                    checks++;
                    if (m_err[i] !== 1'b0 || m_rdata[i*DW +: DW] !== '0) begin
                        fails++;
                        $display("FAIL idle_out master=%0d err=%b rdata=%h expected 0", i, m_err[i], m_rdata[i*DW +: DW]);
                    end
                end
            end
            checks++;
            if (s_we != '0 && !wr_seen) begin
                fails++;
                $display("FAIL stray_we s_we=%b expected 0", s_we);
            end
        end
    end

    initial begin
        for (int i = 0; i < NM; i++) begin
            req_a[i]  = 1'b0;
            we_a[i]   = 1'b0;
            addr_a[i] = '0;
            wd_a[i]   = '0;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset_outputs");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // All masters reading back-to-back from reset: strict 0,1,2,3 rotation, one ack per 2 cycles.
        ack_m.delete();
        ack_c.delete();
        fork
            run_master(0, 3, 1'b1);
            run_master(1, 3, 1'b1);
            run_master(2, 3, 1'b1);
            run_master(3, 3, 1'b1);
        join
        checks++;
        if (ack_m.size() != 3*NM) begin
            fails++;
            $display("FAIL rr_count got=%0d expected=%0d", ack_m.size(), 3*NM);
        end
        for (int j = 0; j < ack_m.size(); j++) begin
            checks++;
            if (ack_m[j] != j % NM || (j > 0 && ack_c[j] - ack_c[j-1] != 2)) begin
                fails++;
                $display("FAIL rr_order idx=%0d master=%0d gap=%0d expected master=%0d gap=2",
                         j, ack_m[j], (j > 0) ? ack_c[j] - ack_c[j-1] : 2, j % NM);
            end
        end

        single(1, 1'b0, 32'h1000_0010, 32'h0,  3, "rd_single");
        single(0, 1'b1, 32'h2000_0004, 32'h5A, 2, "wr_single");
        single(0, 1'b0, 32'hF000_0000, 32'h0,  2, "derr_single");
        single(2, 1'b1, 32'h3000_0008, 32'h77, 2, "derr_write");

        // Reset in the middle of a read data phase drops the access.
        issue(0, 1'b0, 32'h1000_0040, 32'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (m_ack[0] !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_ack got=%b expected=1", m_ack[0]);
        end
        rst = 1'b0;
        #1;
        check_zero("mid_reset_outputs");
        exp_q[0].delete();
        req_a[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        single(1, 1'b0, 32'h1000_0020, 32'h0, 3, "post_reset_rd");

        fork
            run_master(0, 25, 1'b0);
            run_master(1, 25, 1'b0);
            run_master(2, 25, 1'b0);
            run_master(3, 25, 1'b0);
        join

        repeat (4) @(negedge clk);
        for (int i = 0; i < NM; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                fails++;
                $display("FAIL leftover master=%0d pending=%0d expected=0", i, exp_q[i].size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
